core_mem_access: RTL and testbench
==================================

Name: core_mem_access

Overview:
- Memory-access pipeline stage between execute and the write stage.
- Turns execute-stage load/store requests into single-outstanding data-bus transactions and aligns store data with byte selects.
- Stalls upstream while a transaction is pending.
- Registers the raw read word plus pass-through fields for the write stage, which does load extraction and sign extension.

Parameters:
- ADDR_W, 32, data-bus byte-address width; bus carries word address [ADDR_W-1:2].

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_valid  in  1  execute-stage instruction valid.
- i_mem_read  in  1  instruction is a load.
- i_mem_write  in  1  instruction is a store.
- i_alu_result  in  32  effective address, or ALU result for non-memory ops.
- i_rs2  in  32  store source data.
- i_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- i_res_src  in  2  result-source select, passed through.
- i_pc_p4  in  30  PC+4 [31:2], passed through.
- i_rd  in  5  destination register, passed through.
- i_reg_write  in  1  register-write enable, passed through.
- o_stall  out  1  upstream must hold its outputs this cycle.
- o_bus_req  out  1  bus request.
- o_bus_we  out  1  1 = write.
- o_bus_addr  out  ADDR_W-2  word address.
- o_bus_wdata  out  32  lane-aligned write data.
- o_bus_wsel  out  4  byte-lane enables.
- i_bus_ack  in  1  transaction complete; read data valid this cycle.
- i_bus_rdata  in  32  read word.
- o_valid  out  1  write-stage instruction valid.
- o_fault  out  1  misaligned or illegal-size access.
- o_data  out  32  raw bus read word.
- o_alu_result  out  32  registered i_alu_result.
- o_funct3  out  3  registered i_funct3.
- o_res_src  out  2  registered i_res_src.
- o_pc_p4  out  30  registered i_pc_p4.
- o_rd  out  5  registered i_rd.
- o_reg_write  out  1  registered write enable, forced 0 on fault.

Behaviour:
- Reset (i_reset_n=0 at edge): state IDLE; every registered output 0. That covers o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wsel, o_valid, o_fault, o_data and all pass-through fields. Reset mid-transaction abandons the request; an ack arriving later is ignored.
- FSM states: IDLE and WAIT.
- Memory op: mem = i_valid & (i_mem_read | i_mem_write).
- Legal/aligned op, all of:
  - funct3 000/100: any address.
  - funct3 001/101: addr[0]=0.
  - funct3 010: addr[1:0]=00.
  - Stores: only 000/001/010 legal.
- IDLE, non-mem or i_valid=0:
  - o_stall=0.
  - Output register loads inputs next edge with o_valid=i_valid, o_fault=0, o_data holds its previous value.
  - Latency 1 cycle.
- IDLE, mem and illegal:
  - o_stall=0, no bus request.
  - Next edge: o_valid=1, o_fault=1, o_reg_write=0.
- IDLE, mem and legal:
  - o_stall=1; go to WAIT.
  - Registered o_bus_req=1 and o_bus_we=i_mem_write.
  - o_bus_addr = addr[ADDR_W-1:2].
  - Bus-side o_valid=0 next edge.
- Store lane steering:
  - SB: wdata = {4{rs2[7:0]}}, wsel = 0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wsel = 0011 (addr[1]=0) or 1100.
  - SW: wdata = rs2, wsel = 1111.
  - Loads: wsel = 1111, wdata = 0.
- WAIT:
  - Bus outputs held stable until ack.
  - o_stall = ~i_bus_ack.
  - Upstream inputs are held constant, so the pass-through fields come from the inputs.
  - On i_bus_ack: next edge o_bus_req=0, state IDLE, o_valid=1, o_fault=0.
  - On ack, o_data = i_bus_rdata for loads; for stores o_data holds.
  - Minimum memory-op latency is 2 cycles (issue + ack); each extra wait cycle adds 1.
- i_bus_ack in IDLE is ignored.
- Only one outstanding transaction; a new request cannot issue in the cycle after ack. That is an inherent IDLE pass: the next op sees IDLE.
- o_data is never sign-extended here.

Test Plan:
- Reset: assert i_reset_n=0 with a pending WAIT and ack=1 on the same edge → all outputs 0, state IDLE, o_bus_req=0.
- Non-mem pass-through:
  - Stimulus: i_valid=1, i_alu_result=0x1234_5678, rd=5, reg_write=1.
  - Response: one cycle later o_valid=1, o_alu_result=0x12345678, o_rd=5; o_stall never 1.
- Load word, 2 wait cycles:
  - Stimulus: addr 0x0000_1008, funct3=010.
  - Response: o_bus_req=1, o_bus_addr=0x402, wsel=1111, o_stall high 3 cycles.
  - On ack with rdata=0xDEADBEEF: next cycle o_data=0xDEADBEEF, o_valid=1, o_bus_req=0.
- Store byte:
  - Stimulus: addr 0x...3, rs2=0xAABBCCDD, funct3=000, immediate ack.
  - Response: wdata=0xDDDDDDDD, wsel=1000, we=1, total latency 2 cycles.
- Store half: addr[1]=1, rs2=0x0000BEEF → wdata=0xBEEFBEEF, wsel=1100.
- Misaligned:
  - Stimulus: LW at 0x...2, or SH at 0x...1.
  - Response: no o_bus_req, o_stall=0; next cycle o_valid=1, o_fault=1, o_reg_write=0.

Source files
------------

// File: rtl/core_mem_access.sv
// Memory-access stage: turns execute-stage loads/stores into single-outstanding
// data-bus transactions and registers the raw read word plus pass-through fields.
module core_mem_access #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [31:0]       i_alu_result,
  input  logic [31:0]       i_rs2,
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_res_src,
  input  logic [29:0]       i_pc_p4,
  input  logic [4:0]        i_rd,
  input  logic              i_reg_write,
  output logic              o_stall,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-3:0] o_bus_addr,
  output logic [31:0]       o_bus_wdata,
  output logic [3:0]        o_bus_wsel,
  input  logic              i_bus_ack,
  input  logic [31:0]       i_bus_rdata,
  output logic              o_valid,
  output logic              o_fault,
  output logic [31:0]       o_data,
  output logic [31:0]       o_alu_result,
  output logic [2:0]        o_funct3,
  output logic [1:0]        o_res_src,
  output logic [29:0]       o_pc_p4,
  output logic [4:0]        o_rd,
  output logic              o_reg_write
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_nx;
  logic        is_mem;
  logic        size_ok;
  logic        legal;
  logic        issue;
  logic [31:0] wdata_nx;
  logic [3:0]  wsel_nx;

  // Access legality and store lane steering, decoded straight from the request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    size_ok  = 1'b0;
    wdata_nx = '0;
    wsel_nx  = 4'b1111;
    is_mem   = i_valid & (i_mem_read | i_mem_write);

    case (i_funct3)
      3'b000, 3'b100: size_ok = 1'b1;
      3'b001, 3'b101: size_ok = ~i_alu_result[0];
      3'b010:         size_ok = (i_alu_result[1:0] == 2'b00);
      default:        size_ok = 1'b0;
    endcase
    // Stores have no unsigned variants.
    legal = size_ok & ~(i_mem_write & i_funct3[2]);
    issue = is_mem & legal;

    if (i_mem_write) begin
      case (i_funct3[1:0])
        2'b00: begin
          wdata_nx = {4{i_rs2[7:0]}};
          wsel_nx  = 4'b0001 << i_alu_result[1:0];
        end
        2'b01: begin
          wdata_nx = {2{i_rs2[15:0]}};
          wsel_nx  = i_alu_result[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_nx = i_rs2;
          wsel_nx  = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    o_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          state_nx = WAIT;
          o_stall  = 1'b1;
        end
      end
      WAIT: begin
        o_stall = ~i_bus_ack;
        if (i_bus_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_bus_req    <= 1'b0;
      o_bus_we     <= 1'b0;
      o_bus_addr   <= '0;
      o_bus_wdata  <= '0;
      o_bus_wsel   <= '0;
      o_valid      <= 1'b0;
      o_fault      <= 1'b0;
      o_data       <= '0;
      o_alu_result <= '0;
      o_funct3     <= '0;
      o_res_src    <= '0;
      o_pc_p4      <= '0;
      o_rd         <= '0;
      o_reg_write  <= 1'b0;
    end else begin
      // Upstream holds its outputs while stalled, so pass-through can load every cycle.
      o_alu_result <= i_alu_result;
      o_funct3     <= i_funct3;
      o_res_src    <= i_res_src;
      o_pc_p4      <= i_pc_p4;
      o_rd         <= i_rd;
      o_reg_write  <= i_reg_write;
      o_fault      <= 1'b0;

      case (state)
        IDLE: begin
          if (is_mem && !legal) begin
            o_valid     <= 1'b1;
            o_fault     <= 1'b1;
            o_reg_write <= 1'b0;
          end else if (issue) begin
            o_valid     <= 1'b0;
            o_bus_req   <= 1'b1;
            o_bus_we    <= i_mem_write;
            o_bus_addr  <= i_alu_result[ADDR_W-1:2];
            o_bus_wdata <= wdata_nx;
            o_bus_wsel  <= wsel_nx;
          end else begin
            o_valid <= i_valid;
          end
        end
        WAIT: begin
          if (i_bus_ack) begin
            o_valid   <= 1'b1;
            o_bus_req <= 1'b0;
            if (!o_bus_we) o_data <= i_bus_rdata;
          end else begin
            o_valid <= 1'b0;
          end
        end
        default: o_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_access.sv
// Self-checking bench for core_mem_access: directed loads/stores with a
// transaction-level reference model compared every cycle.
module tb_core_mem_access;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, valid, mem_read, mem_write, reg_write;
  logic [31:0] alu, rs2, rdata;
  logic [2:0]  f3;
  logic [1:0]  res_src;
  logic [29:0] pc_p4;
  logic [4:0]  rd;
  logic        auto_ack, man_ack;
  logic        auto_ack_val = 1'b0;
  wire         ack = auto_ack ? auto_ack_val : man_ack;
  int          ack_wait;
  int          ack_cnt = 0;

  logic        stall, bus_req, bus_we, o_valid, o_fault, o_reg_write;
  logic [29:0] bus_addr, o_pc_p4;
  logic [31:0] bus_wdata, o_data, o_alu;
  logic [3:0]  bus_wsel;
  logic [2:0]  o_f3;
  logic [1:0]  o_res_src;
  logic [4:0]  o_rd;

  core_mem_access #(.ADDR_W(32)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .i_mem_read(mem_read),
    .i_mem_write(mem_write), .i_alu_result(alu), .i_rs2(rs2), .i_funct3(f3),
    .i_res_src(res_src), .i_pc_p4(pc_p4), .i_rd(rd), .i_reg_write(reg_write),
    .o_stall(stall), .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
    .o_bus_wdata(bus_wdata), .o_bus_wsel(bus_wsel), .i_bus_ack(ack), .i_bus_rdata(rdata),
    .o_valid(o_valid), .o_fault(o_fault), .o_data(o_data), .o_alu_result(o_alu),
    .o_funct3(o_f3), .o_res_src(o_res_src), .o_pc_p4(o_pc_p4), .o_rd(o_rd),
    .o_reg_write(o_reg_write)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus slave: acks after ack_wait extra cycles of an outstanding request.
  always @(posedge clk) begin
    #1;
    if (bus_req === 1'b1) begin
      if (ack_cnt >= ack_wait) begin
        auto_ack_val = 1'b1;
        ack_cnt      = 0;
      end else begin
        auto_ack_val = 1'b0;
        ack_cnt++;
      end
    end else begin
      auto_ack_val = 1'b0;
      ack_cnt      = 0;
    end
  end

  // ---------------- reference model ----------------
  function automatic bit legal_op(input logic [2:0] f, input logic [31:0] a, input logic w);
    int n;
    if (f == 3'd3 || f > 3'd5) return 1'b0;
    if (w && f > 3'd2) return 1'b0;
    n = 1 << f[1:0];
    return (int'(a[1:0]) % n) == 0;
  endfunction

  function automatic logic [35:0] store_lanes(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] d, input logic w);
    int unsigned n, rep;
    longint unsigned mask;
    logic [31:0] wd;
    logic [3:0]  ws;
    if (!w) return {4'hF, 32'h0};
    n    = 1 << f[1:0];
    mask = (64'd1 << (8 * n)) - 1;
    rep  = (n == 1) ? 32'h0101_0101 : (n == 2) ? 32'h0001_0001 : 32'h1;
    wd   = 32'((longint'(d) & mask) * rep);
    ws   = 4'(((1 << n) - 1) << a[1:0]);
    return {ws, wd};
  endfunction

  bit          ready = 1'b0;
  bit          m_pending;
  logic        e_req, e_we, e_valid, e_fault, e_rw;
  logic [29:0] e_addr, e_pc;
  logic [31:0] e_wd, e_data, e_alu;
  logic [3:0]  e_ws;
  logic [2:0]  e_f3;
  logic [1:0]  e_res;
  logic [4:0]  e_rd;

  always @(posedge clk) begin
    logic mem;
    logic [35:0] ln;
    mem = valid & (mem_read | mem_write);
    if (!reset_n) begin
      m_pending = 0;
      {e_req, e_we, e_addr, e_wd, e_ws, e_valid, e_fault, e_data} = '0;
      {e_alu, e_f3, e_res, e_pc, e_rd, e_rw} = '0;
      ready = 1'b1;
    end else begin
      e_alu = alu; e_f3 = f3; e_res = res_src; e_pc = pc_p4; e_rd = rd;
      e_fault = 1'b0;
      e_rw    = reg_write;
      if (m_pending) begin
        e_valid = ack;
        if (ack) begin
          m_pending = 0;
          e_req     = 1'b0;
          if (!e_we) e_data = rdata;
        end
      end else if (mem && !legal_op(f3, alu, mem_write)) begin
        e_valid = 1'b1;
        e_fault = 1'b1;
        e_rw    = 1'b0;
      end else if (mem) begin
        m_pending = 1;
        ln        = store_lanes(f3, alu, rs2, mem_write);
        e_valid   = 1'b0;
        e_req     = 1'b1;
        e_we      = mem_write;
        e_addr    = alu[31:2];
        e_wd      = ln[31:0];
        e_ws      = ln[35:32];
      end else begin
        e_valid = valid;
      end
    end
  end

  function automatic logic exp_stall();
    if (m_pending) return ~ack;
    return valid & (mem_read | mem_write) & legal_op(f3, alu, mem_write);
  endfunction

  always @(negedge clk) begin
    if (ready) begin
      check("stall", stall, exp_stall());
      check("bus_req", bus_req, e_req);
      check("bus_we", bus_we, e_we);
      check("bus_addr", bus_addr, e_addr);
      check("bus_wdata", bus_wdata, e_wd);
      check("bus_wsel", bus_wsel, e_ws);
      check("valid", o_valid, e_valid);
      check("fault", o_fault, e_fault);
      check("data", o_data, e_data);
      check("alu_result", o_alu, e_alu);
      check("funct3", o_f3, e_f3);
      check("res_src", o_res_src, e_res);
      check("pc_p4", o_pc_p4, e_pc);
      check("rd", o_rd, e_rd);
      check("reg_write", o_reg_write, e_rw);
    end
  end

  // ---------------- directed stimulus ----------------
  int          stalls;
  bit          seen_req, done;
  logic        cap_we;
  logic [29:0] cap_addr;
  logic [31:0] cap_wd;
  logic [3:0]  cap_ws;

  task automatic drive(input logic v, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f, input logic [4:0] dst);
    valid = v; mem_read = r; mem_write = w; alu = a; rs2 = d; f3 = f; rd = dst;
    reg_write = 1'b1; res_src = 2'b01; pc_p4 = a[31:2] + 30'd1;
  endtask

  // Holds the current instruction until the stage accepts it; records bus activity.
  task automatic accept();
    logic s;
    stalls = 0; seen_req = 0; done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      s = stall;
      if (bus_req === 1'b1) begin
        seen_req = 1; cap_we = bus_we; cap_addr = bus_addr; cap_wd = bus_wdata; cap_ws = bus_wsel;
      end
      @(posedge clk); #2;
      if (s !== 1'b1) begin
        done = 1;
        break;
      end
      stalls++;
    end
    check("accept_done", done, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0; auto_ack = 1'b1; man_ack = 1'b0; ack_wait = 0; rdata = '0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_bus_req", bus_req, 1'b0);

    // Non-memory pass-through
    drive(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 3'b000, 5'd5);
    accept();
    check("alu_stalls", stalls, 0);
    check("alu_valid", o_valid, 1'b1);
    check("alu_result_lit", o_alu, 32'h1234_5678);
    check("alu_rd", o_rd, 5'd5);
    check("alu_rw", o_reg_write, 1'b1);

    // Load word with two wait cycles
    ack_wait = 2; rdata = 32'hDEAD_BEEF;
    drive(1'b1, 1'b1, 1'b0, 32'h0000_1008, 32'h0, 3'b010, 5'd7);
    accept();
    check("lw_stalls", stalls, 3);
    check("lw_req_seen", seen_req, 1'b1);
    check("lw_addr", cap_addr, 30'h402);
    check("lw_wsel", cap_ws, 4'b1111);
    check("lw_we", cap_we, 1'b0);
    check("lw_data", o_data, 32'hDEAD_BEEF);
    check("lw_valid", o_valid, 1'b1);
    check("lw_req_done", bus_req, 1'b0);

    // Store byte, immediate ack
    ack_wait = 0; rdata = 32'h5555_5555;
    drive(1'b1, 1'b0, 1'b1, 32'h0000_2003, 32'hAABB_CCDD, 3'b000, 5'd0);
    accept();
    check("sb_stalls", stalls, 1);
    check("sb_wdata", cap_wd, 32'hDDDD_DDDD);
    check("sb_wsel", cap_ws, 4'b1000);
    check("sb_we", cap_we, 1'b1);
    check("sb_data_hold", o_data, 32'hDEAD_BEEF);

    // Store half, upper lanes
    drive(1'b1, 1'b0, 1'b1, 32'h0000_2002, 32'h0000_BEEF, 3'b001, 5'd0);
    accept();
    check("sh_wdata", cap_wd, 32'hBEEF_BEEF);
    check("sh_wsel", cap_ws, 4'b1100);

    // Misaligned word load
    drive(1'b1, 1'b1, 1'b0, 32'h0000_2002, 32'h0, 3'b010, 5'd9);
    accept();
    check("lw_mis_stalls", stalls, 0);
    check("lw_mis_req", seen_req, 1'b0);
    check("lw_mis_valid", o_valid, 1'b1);
    check("lw_mis_fault", o_fault, 1'b1);
    check("lw_mis_rw", o_reg_write, 1'b0);

    // Misaligned half store
    drive(1'b1, 1'b0, 1'b1, 32'h0000_2001, 32'h1111_2222, 3'b001, 5'd0);
    accept();
    check("sh_mis_req", seen_req, 1'b0);
    check("sh_mis_fault", o_fault, 1'b1);

    // Unsigned-size store is illegal
    drive(1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'h1111_2222, 3'b100, 5'd0);
    accept();
    check("sbu_fault", o_fault, 1'b1);

    // Byte load unsigned: raw word returned, no extraction
    ack_wait = 1; rdata = 32'h1234_5680;
    drive(1'b1, 1'b1, 1'b0, 32'h0000_3001, 32'h0, 3'b100, 5'd3);
    accept();
    check("lbu_stalls", stalls, 2);
    check("lbu_wsel", cap_ws, 4'b1111);
    check("lbu_data", o_data, 32'h1234_5680);

    // Bubble
    drive(1'b0, 1'b0, 1'b0, 32'h0000_00AA, 32'h0, 3'b000, 5'd0);
    accept();
    check("bubble_valid", o_valid, 1'b0);

    // Reset while a transaction is pending, with ack on the same edge
    auto_ack = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 3'b010, 5'd4);
    repeat (3) @(posedge clk);
    #2;
    check("mid_req", bus_req, 1'b1);
    reset_n = 1'b0; man_ack = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
    @(posedge clk); #2;
    check("rst2_req", bus_req, 1'b0);
    check("rst2_addr", bus_addr, 30'h0);
    check("rst2_wsel", bus_wsel, 4'h0);
    check("rst2_valid", o_valid, 1'b0);
    check("rst2_data", o_data, 32'h0);
    check("rst2_rd", o_rd, 5'd0);
    reset_n = 1'b1;
    @(posedge clk); #2;
    check("late_ack_valid", o_valid, 1'b0);
    check("late_ack_data", o_data, 32'h0);
    check("late_ack_req", bus_req, 1'b0);
    man_ack = 1'b0; auto_ack = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
